// File: rtl/musa_pkg.sv
// Shared definitions for the MUSA core front end: program-counter FSM states
// and default PC geometry.
package musa_pkg;

    typedef enum logic [1:0] {
        PC_RUN      = 2'd0,
        PC_RET_WAIT = 2'd1,
        PC_HALT     = 2'd2
    } pc_state_t;

    localparam int PC_WIDTH_DEFAULT = 18;
    localparam int RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/pc_stack_tracker.sv
// Shadow occupancy counter for the downstream return-address stack. Grants
// push/pop requests and raises sticky overflow/underflow flags on misuse.
module pc_stack_tracker #(
    parameter int STACK_DEPTH = 32,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_en,
    input  logic          i_call,
    input  logic          i_ret,
    output logic          o_push_ok,
    output logic          o_pop_ok,
    output logic [DW-1:0] o_depth,
    output logic          o_overflow,
    output logic          o_underflow
);

    logic [DW-1:0] r_depth;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_full;
    logic          w_empty;
    logic          w_ret_req;
    logic          w_call_req;

    assign w_full     = (r_depth == DW'(STACK_DEPTH));
    assign w_empty    = (r_depth == '0);
    // ret outranks call, so a simultaneous call never reaches the stack
    assign w_ret_req  = i_req_en & i_ret;
    assign w_call_req = i_req_en & ~i_ret & i_call;

    assign o_pop_ok    = w_ret_req & ~w_empty;
    assign o_push_ok   = w_call_req & ~w_full;
    assign o_depth     = r_depth;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (o_pop_ok) begin
                r_depth <= r_depth - DW'(1);
            end else if (o_push_ok) begin
                r_depth <= r_depth + DW'(1);
            end
            if (w_ret_req && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_call_req && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter and next-PC selection for the MUSA core, driving push/pop
// strobes to the return-address stack that sits downstream.
//
//   state       | meaning
//   PC_RUN      | normal fetch; pc advances, branches, calls, returns
//   PC_RET_WAIT | one bubble while the popped return address arrives
//   PC_HALT     | stack misuse detected; frozen until reset
module pc_unit
    import musa_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_PC_DEFAULT),
    parameter int               STACK_DEPTH = 32,
    localparam int              DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic [WIDTH-1:0] call_target,
    input  logic             ret,
    input  logic [WIDTH-1:0] stack_top,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             stack_push,
    output logic             stack_pop,
    output logic [WIDTH-1:0] stack_wr_data,
    output logic [DW-1:0]    depth,
    output logic             overflow,
    output logic             underflow
);

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_req_en;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_pc_inc = r_pc + WIDTH'(1);
    assign w_req_en = (r_state == PC_RUN) && !stall;
    assign pc       = r_pc;

    pc_stack_tracker #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_en   (w_req_en),
        .i_call     (call),
        .i_ret      (ret),
        .o_push_ok  (w_push_ok),
        .o_pop_ok   (w_pop_ok),
        .o_depth    (depth),
        .o_overflow (overflow),
        .o_underflow(underflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PC_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        pc_valid      = 1'b0;
        stack_push    = 1'b0;
        stack_pop     = 1'b0;
        stack_wr_data = '0;
        case (r_state)
            PC_RUN: begin
                pc_valid = 1'b1;
                if (!stall) begin
                    if (ret) begin
                        if (w_pop_ok) begin
                            stack_pop   = 1'b1;
                            w_state_nxt = PC_RET_WAIT;
                        end else begin
                            w_state_nxt = PC_HALT;
                        end
                    end else if (call) begin
                        if (w_push_ok) begin
                            stack_push    = 1'b1;
                            stack_wr_data = w_pc_inc;
                            w_pc_nxt      = call_target;
                        end else begin
                            w_state_nxt = PC_HALT;
                        end
                    end else if (jump) begin
                        w_pc_nxt = jump_target;
                    end else if (branch_taken) begin
                        w_pc_nxt = branch_target;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            PC_RET_WAIT: begin
                w_pc_nxt    = stack_top;
                w_state_nxt = PC_RUN;
            end
            PC_HALT: begin
                w_state_nxt = PC_HALT;
            end
            default: begin
                w_state_nxt = PC_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model compared every
// cycle, directed scenarios, and literal spot checks on key values.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [17:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [17:0] jump_target = '0;
    logic        call = 1'b0;
    logic [17:0] call_target = '0;
    logic        ret = 1'b0;
    logic [17:0] stack_top;
    logic [17:0] pc;
    logic        pc_valid;
    logic        stack_push;
    logic        stack_pop;
    logic [17:0] stack_wr_data;
    logic [5:0]  depth;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .call         (call),
        .call_target  (call_target),
        .ret          (ret),
        .stack_top    (stack_top),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .stack_push   (stack_push),
        .stack_pop    (stack_pop),
        .stack_wr_data(stack_wr_data),
        .depth        (depth),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Return-address stack emulator, driven by strobes sampled mid-cycle.
    logic [17:0] emu_q[$];
    logic [17:0] emu_top = '0;
    logic        s_push = 1'b0;
    logic        s_pop = 1'b0;
    logic [17:0] s_wr = '0;
    assign stack_top = emu_top;

    always @(negedge clk) begin
        s_push = stack_push;
        s_pop  = stack_pop;
        s_wr   = stack_wr_data;
    end

    always @(posedge clk) begin
        logic [17:0] t;
        if (s_push) begin
            emu_q.push_back(s_wr);
            emu_top <= s_wr;
        end else if (s_pop && emu_q.size() > 0) begin
            t = emu_q.pop_back();
            emu_top <= t;
        end
    end

    // Reference model: a queue stands in for the stack, plus halted/waiting flags.
    logic [17:0] m_pc = '0;
    logic        m_halt = 1'b0;
    logic        m_wait = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [17:0] m_ret_addr = '0;
    logic [17:0] m_stack[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = '0; m_halt = 0; m_wait = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
        end else if (m_halt) begin
        end else if (m_wait) begin
            m_pc = m_ret_addr;
            m_wait = 0;
        end else if (stall) begin
        end else if (ret) begin
            if (m_stack.size() == 0) begin
                m_unf = 1; m_halt = 1;
            end else begin
                m_ret_addr = m_stack.pop_back();
                m_wait = 1;
            end
        end else if (call) begin
            if (m_stack.size() == 32) begin
                m_ovf = 1; m_halt = 1;
            end else begin
                m_stack.push_back(m_pc + 18'd1);
                m_pc = call_target;
            end
        end else if (jump) m_pc = jump_target;
        else if (branch_taken) m_pc = branch_target;
        else m_pc = m_pc + 18'd1;
    end

    always @(negedge clk) begin
        logic        run, e_push, e_pop;
        logic [17:0] e_wr;
        run    = !m_halt && !m_wait && !stall;
        e_pop  = run && ret && (m_stack.size() > 0);
        e_push = run && !ret && call && (m_stack.size() < 32);
        e_wr   = e_push ? (m_pc + 18'd1) : 18'd0;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("pc_valid", 32'(pc_valid), 32'(!m_halt && !m_wait));
        chk("stack_push", 32'(stack_push), 32'(e_push));
        chk("stack_pop", 32'(stack_pop), 32'(e_pop));
        chk("stack_wr_data", 32'(stack_wr_data), 32'(e_wr));
        chk("depth", 32'(depth), 32'(m_stack.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    end

    task automatic set_in(input logic s, input logic r, input logic c, input logic j,
                          input logic b, input logic [17:0] ct, input logic [17:0] jt,
                          input logic [17:0] bt);
        stall = s; ret = r; call = c; jump = j; branch_taken = b;
        call_target = ct; jump_target = jt; branch_target = bt;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 18'h0, 18'h0, 18'h0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_valid", 32'(pc_valid), 32'h1);
        chk("rst_flags", 32'({overflow, underflow}), 32'h0);
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        tick(2);
        rst_n = 1'b1;
        // free-running
        chk("p1_pc0", 32'(pc), 32'h0);
        tick(4);
        chk("p1_pc4", 32'(pc), 32'h4);
        // call from 0x10
        set_in(0, 0, 0, 1, 0, 18'h0, 18'h00010, 18'h0);
        tick(1);
        set_in(0, 0, 1, 0, 0, 18'h00200, 18'h0, 18'h0);
        chk("p2_push", 32'(stack_push), 32'h1);
        chk("p2_wr", 32'(stack_wr_data), 32'h11);
        tick(1);
        idle();
        chk("p2_pc", 32'(pc), 32'h200);
        chk("p2_depth", 32'(depth), 32'h1);
        tick(2);
        // return
        set_in(0, 1, 0, 0, 0, 18'h0, 18'h0, 18'h0);
        chk("p3_pop", 32'(stack_pop), 32'h1);
        tick(1);
        idle();
        chk("p3_bubble", 32'(pc_valid), 32'h0);
        tick(1);
        chk("p3_pc", 32'(pc), 32'h11);
        chk("p3_valid", 32'(pc_valid), 32'h1);
        chk("p3_depth", 32'(depth), 32'h0);
        // underflow
        set_in(0, 1, 0, 0, 0, 18'h0, 18'h0, 18'h0);
        chk("p4_nopop", 32'(stack_pop), 32'h0);
        tick(1);
        idle();
        chk("p4_unf", 32'(underflow), 32'h1);
        chk("p4_valid", 32'(pc_valid), 32'h0);
        tick(3);
        chk("p4_frozen", 32'(pc), 32'h11);
        reset_pulse();
        // fill the stack then overflow
        for (int i = 0; i < 32; i++) begin
            set_in(0, 0, 1, 0, 0, 18'(18'h1000 + i * 4), 18'h0, 18'h0);
            tick(1);
        end
        idle();
        chk("p5_full", 32'(depth), 32'd32);
        set_in(0, 0, 1, 0, 0, 18'h2000, 18'h0, 18'h0);
        chk("p5_nopush", 32'(stack_push), 32'h0);
        tick(1);
        idle();
        chk("p5_ovf", 32'(overflow), 32'h1);
        chk("p5_halt", 32'(pc_valid), 32'h0);
        tick(2);
        reset_pulse();
        // call and ret together at depth 1
        set_in(0, 0, 1, 0, 0, 18'h00050, 18'h0, 18'h0);
        tick(1);
        set_in(0, 1, 1, 0, 0, 18'h00099, 18'h0, 18'h0);
        chk("p5_both_pop", 32'(stack_pop), 32'h1);
        chk("p5_both_push", 32'(stack_push), 32'h0);
        tick(1);
        idle();
        chk("p5_both_depth", 32'(depth), 32'h0);
        tick(1);
        chk("p5_both_pc", 32'(pc), 32'h1);
        // wrap and stall
        set_in(0, 0, 0, 1, 0, 18'h0, 18'h3FFFF, 18'h0);
        tick(1);
        idle();
        tick(1);
        chk("p6_wrap", 32'(pc), 32'h0);
        set_in(1, 0, 0, 1, 0, 18'h0, 18'h00123, 18'h0);
        tick(3);
        chk("p6_stall_pc", 32'(pc), 32'h0);
        set_in(0, 0, 0, 1, 0, 18'h0, 18'h00123, 18'h0);
        tick(1);
        idle();
        chk("p6_jump", 32'(pc), 32'h123);
        // priorities and misc
        set_in(0, 0, 0, 0, 1, 18'h0, 18'h0, 18'h00777);
        tick(1);
        chk("br_pc", 32'(pc), 32'h777);
        set_in(0, 0, 0, 1, 1, 18'h0, 18'h00010, 18'h00020);
        tick(1);
        chk("jmp_over_br", 32'(pc), 32'h10);
        set_in(1, 0, 1, 0, 0, 18'h00300, 18'h0, 18'h0);
        chk("stall_nopush", 32'(stack_push), 32'h0);
        tick(2);
        set_in(0, 0, 0, 1, 0, 18'h0, 18'h3FFFF, 18'h0);
        tick(1);
        set_in(0, 0, 1, 0, 0, 18'h00005, 18'h0, 18'h0);
        chk("wr_wrap", 32'(stack_wr_data), 32'h0);
        tick(1);
        set_in(0, 1, 0, 0, 0, 18'h0, 18'h0, 18'h0);
        tick(1);
        idle();
        chk("retwait_valid", 32'(pc_valid), 32'h0);
        reset_pulse();
        tick(2);
        chk("post_rst_pc", 32'(pc), 32'h2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
